bit_serializer: RTL
===================

Name: bit_serializer

Overview:
Parallel-to-serial stage directly upstream of the serial sequence detectors (1011 Moore FSMs). It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on ser_out, which drives the detector's `in` input. Back-to-back words stream with no gap, so detectors see a continuous bit stream and overlapping patterns across word boundaries.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
clk  input  1  single system clock; all logic on the rising edge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge)
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a valid word
din_ready  output  1  block accepts din this cycle
ser_out  output  1  serial bit to the detector `in`; forced to 0 when ser_valid = 0
ser_valid  output  1  ser_out carries a data (or parity) bit this cycle
busy  output  1  a word is in flight (state is not IDLE)

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state goes to IDLE; shift register and counter clear.
  - Outputs: ser_out = 0, ser_valid = 0, busy = 0. din_ready = 1 once rst deasserts.
  - Applies mid-word: the partial word is discarded, and ser_out is 0 on the next cycle.
- Handshake:
  - Transfer occurs on a clk edge where din_valid = 1 and din_ready = 1.
  - din is sampled only at the transfer.
  - din_valid may stay high while din_ready = 0; no word is lost or duplicated.
- State machine: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
  - IDLE: din_ready = 1. On transfer, load the shift register, clear cnt, and go to SHIFT.
  - SHIFT: ser_valid = 1, and ser_out is the current bit (MSB or LSB per MSB_FIRST). cnt increments each cycle, and the register shifts by one.
  - When cnt = WIDTH-1, the last bit is on ser_out. Next state:
    - PARITY if the macro is defined;
    - otherwise SHIFT with a newly loaded word if a transfer occurs that cycle;
    - otherwise IDLE.
  - din_ready in SHIFT = (cnt == WIDTH-1) and the macro is not defined.
- Latency: the first bit of a word appears on ser_out on the cycle after the transfer edge. A word occupies exactly WIDTH ser_valid cycles (WIDTH+1 with parity).
- Back-to-back: a transfer in the last-bit cycle gives gapless output; ser_valid stays 1 continuously.
- Counter width is $clog2(WIDTH) and wraps to 0 when a new word loads. It never reaches WIDTH.
- Registered outputs: ser_out, ser_valid, and busy come from state/registers only, with no combinational path from din. din_ready is decoded from state and cnt only.

Optional Feature:
SER_PARITY_EN
- Defined: after the last data bit, PARITY emits one cycle with ser_valid = 1 and ser_out = even parity (XOR of all WIDTH bits of the word).
  - din_ready = 1 in PARITY.
  - A transfer in PARITY goes to SHIFT gaplessly; otherwise the next state is IDLE.
  - din_ready is 0 throughout SHIFT.
- Not defined: the PARITY state and parity logic are absent, and behaviour is exactly as above.

Decomposition:
- Package ser_pkg holds:
  - the state enum (IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2);
  - the localparam for counter width;
  - an idle-level constant SER_IDLE = 1'b0.
- One natural sub-module: ser_bit_cnt, a WIDTH-bounded bit counter with load/clear and a last flag (cnt == WIDTH-1). Everything else stays in bit_serializer.

Test Plan:
- Single word: reset, then one transfer of 8'b1011_0000 (MSB_FIRST = 1).
  - ser_out = 1,0,1,1,0,0,0,0 on the 8 cycles after the transfer, with ser_valid high for exactly 8 cycles.
  - din_ready is low for cycles 1-7 after the transfer.
  - A downstream 1011 detector flags exactly once.
- Back-to-back: din_valid held high with words 8'hB0 then 8'h0B.
  - ser_valid stays high for 16 consecutive cycles with no gap.
  - The bit stream is 10110000_00001011.
  - Each word is accepted exactly once.
- Stall: din_valid high with din = 8'hFF while busy.
  - No transfer occurs until the last-bit cycle.
  - Exactly 8 ones follow the current word.
- Reset mid-word: rst = 0 at the 4th bit of 8'hAA.
  - Next cycle: ser_out = 0, ser_valid = 0, busy = 0.
  - din_ready = 1 on the first cycle after rst returns high; no residual bits appear.
- LSB-first: MSB_FIRST = 0 with din = 8'b0000_1101 gives ser_out = 1,0,1,1,0,0,0,0.
- Parity (SER_PARITY_EN defined): word 8'b1011_0000 gives 8 data bits then ser_out = 1 (three ones), so ser_valid is high for 9 cycles. With 8'hFF the parity bit is 0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and constants for the parallel-to-serial stage (bit_serializer).
// Holds the FSM encoding, counter sizing and the serial idle level.
// Pure declarations: no logic, no latency, no flow control of its own.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

  localparam int   SER_DEF_WIDTH = 8;
  localparam int   SER_CNT_W     = $clog2(SER_DEF_WIDTH);
  localparam logic SER_IDLE      = 1'b0;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_bit_cnt.sv
// Bit position counter for one word: counts 0..WIDTH-1, flags the last bit.
// Latency: last reflects the registered count, no combinational input path.
// Backpressure: none; the owner decides when to clear or advance.
module ser_bit_cnt
  import ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the 1011 detectors; optional parity bit via SER_PARITY_EN.
// Latency: first bit on ser_out the cycle after the transfer; WIDTH (+1 parity) bits per word.
// Backpressure: din_ready only in IDLE and in the final serial cycle, so words stream gaplessly.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy
);

  ser_state_e       state_q;
  ser_state_e       state_d;
  logic [WIDTH-1:0] shreg_q;
  logic             last;
  logic             xfer;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cur_bit;
`ifdef SER_PARITY_EN
  logic             par_q;
`endif

  assign xfer = din_valid & din_ready;

  always_comb begin
    state_d   = state_q;
    din_ready = 1'b0;
    case (state_q)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (last) begin
`ifdef SER_PARITY_EN
          state_d = PARITY;
`else
          din_ready = 1'b1;
          state_d   = din_valid ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        din_ready = 1'b1;
        state_d   = din_valid ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter restarts at every load and also after the last bit, so it never reaches WIDTH.
  assign cnt_clr = xfer | ((state_q == SHIFT) & last);
  assign cnt_inc = (state_q == SHIFT) & ~last;

  ser_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q <= '0;
    end else if (xfer) begin
      shreg_q <= din;
    end else if (state_q == SHIFT) begin
      if (MSB_FIRST != 0) shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
      else                shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else if (xfer) begin
      par_q <= ^din;
    end
  end
`endif

  assign cur_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

  always_comb begin
    ser_valid = 1'b0;
    ser_out   = SER_IDLE;
    case (state_q)
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = cur_bit;
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_out   = par_q;
      end
`endif
      default: begin
        ser_valid = 1'b0;
        ser_out   = SER_IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule
